// File: rtl/alu_pipe_pkg.sv
// Shared decode/config types for the execute-stage ALU.
// Holds the op encoding, register data type and shift-width helper.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } decode_alu_op_t;

    typedef logic [63:0] reg_data_t;

    function automatic int ALU_SHAMT_W(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational integer ALU: full-width ops plus RV64 word mode.
// Word results are sign-extended from bit 31.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  decode_alu_op_t    op,
    input  logic              w32,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    output logic [XLEN-1:0]   result
);

    localparam int SW = ALU_SHAMT_W(XLEN);

    logic            wmode;
    logic [SW-1:0]   shamt;
    logic [4:0]      sh_w;
    logic [31:0]     a_w;
    logic [31:0]     b_w;
    logic [31:0]     r_w;
    logic [31:0]     imm;
    logic            lt_s;
    logic            lt_u;

    // Word-mode 32-bit result and full-width result selection
    always_comb begin
        wmode = w32 && (XLEN == 64);
        shamt = src2[SW-1:0];
        a_w   = src1[31:0];
        b_w   = src2[31:0];
        sh_w  = src2[4:0];
        imm   = {src2[19:0], 12'b0};
        lt_s  = $signed(src1) < $signed(src2);
        lt_u  = src1 < src2;

        r_w = '0;
        unique case (op)
            ALU_ADD: r_w = a_w + b_w;
            ALU_SUB: r_w = a_w - b_w;
            ALU_SLL: r_w = a_w << sh_w;
            ALU_SRL: r_w = a_w >> sh_w;
            ALU_SRA: r_w = $unsigned($signed(a_w) >>> sh_w);
            default: r_w = '0;
        endcase

        result = '0;
        unique case (op)
            ALU_ADD:  result = wmode ? XLEN'($signed(r_w)) : src1 + src2;
            ALU_SUB:  result = wmode ? XLEN'($signed(r_w)) : src1 - src2;
            ALU_AND:  result = src1 & src2;
            ALU_OR:   result = src1 | src2;
            ALU_XOR:  result = src1 ^ src2;
            ALU_SLL:  result = wmode ? XLEN'($signed(r_w)) : src1 << shamt;
            ALU_SRL:  result = wmode ? XLEN'($signed(r_w)) : src1 >> shamt;
            ALU_SRA:  result = wmode ? XLEN'($signed(r_w))
                                     : $unsigned($signed(src1) >>> shamt);
            ALU_SLT:  result = XLEN'(lt_s);
            ALU_SLTU: result = XLEN'(lt_u);
            ALU_LUI:  result = src1 + XLEN'($signed(imm));
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined execute-stage ALU with valid/ready flow control.
// Result computed at accept, then carried through STAGES registers.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_log_fd,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  decode_alu_op_t       i_op,
    input  logic                 i_w32,
    input  logic [XLEN-1:0]      i_src1,
    input  logic [XLEN-1:0]      i_src2,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_dest,
    output logic [TAG_W-1:0]     o_tag
);

    logic                            accept;
    logic [XLEN-1:0]                 alu_res;
    logic [STAGES-1:0]               valid_s;
    logic [STAGES-1:0][XLEN-1:0]     data_s;
    logic [STAGES-1:0][TAG_W-1:0]    tag_s;
    logic [STAGES:0]                 free;

    alu_pipe_core #(.XLEN(XLEN)) u_core (
        .op     (i_op),
        .w32    (i_w32),
        .src1   (i_src1),
        .src2   (i_src2),
        .result (alu_res)
    );

    // A stage can load when it is empty or its content moves on
    always_comb begin
        free[STAGES] = i_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free[k] = ~valid_s[k] | free[k+1];
        end
    end

    assign o_ready = ~i_flush & free[0];
    assign accept  = i_valid & o_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic              in_valid;
        logic [XLEN-1:0]   in_data;
        logic [TAG_W-1:0]  in_tag;
        logic              valid_d, valid_q;
        logic [XLEN-1:0]   data_d, data_q;
        logic [TAG_W-1:0]  tag_d, tag_q;

        if (g == 0) begin : g_head
            assign in_valid = accept;
            assign in_data  = alu_res;
            assign in_tag   = i_tag;
        end else begin : g_body
            assign in_valid = valid_s[g-1];
            assign in_data  = data_s[g-1];
            assign in_tag   = tag_s[g-1];
        end

        // Next stage state: flush kills, otherwise load when free
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            if (i_flush) begin
                valid_d = 1'b0;
            end else if (free[g]) begin
                valid_d = in_valid;
                if (in_valid) begin
                    data_d = in_data;
                    tag_d  = in_tag;
                end
            end
        end

        // Stage registers with synchronous reset
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
            end
        end

        assign valid_s[g] = valid_q;
        assign data_s[g]  = data_q;
        assign tag_s[g]   = tag_q;
    end

    assign o_valid = valid_s[STAGES-1];
    assign o_dest  = data_s[STAGES-1];
    assign o_tag   = tag_s[STAGES-1];

`ifndef SYNTHESIS
    // Accept trace for simulation
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept && i_log_fd != 32'd0) begin
            $display("alu op=%s src1=%h src2=%h w32=%0d dest=%h tag=%0d",
                     i_op.name(), i_src1, i_src2, i_w32, alu_res, i_tag);
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with an in-order expected-result queue.
// Inputs change #1 after posedge; DUT is sampled on negedge.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int XLEN   = 64;
    localparam int STAGES = 3;
    localparam int TAG_W  = 6;

    logic                clk = 1'b0;
    logic                i_rst = 1'b1;
    logic [31:0]         i_log_fd = 32'd0;
    logic                i_flush = 1'b0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    decode_alu_op_t      i_op = ALU_ADD;
    logic                i_w32 = 1'b0;
    logic [XLEN-1:0]     i_src1 = '0;
    logic [XLEN-1:0]     i_src2 = '0;
    logic [TAG_W-1:0]    i_tag = '0;
    logic                o_valid;
    logic                i_ready = 1'b1;
    logic [XLEN-1:0]     o_dest;
    logic [TAG_W-1:0]    o_tag;

    alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_log_fd (i_log_fd),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_w32    (i_w32),
        .i_src1   (i_src1),
        .i_src2   (i_src2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_dest   (o_dest),
        .o_tag    (o_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t              sb[$];
    logic [TAG_W-1:0]  got_tags[$];
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                sb_n = 0;
    logic              last_acc = 1'b0;
    logic              last_ordy = 1'b0;
    logic              lat_chk = 1'b1;
    logic [63:0]       cur_exp = '0;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] model(input decode_alu_op_t op,
                                          input logic w,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [31:0] r;
        logic [63:0] f;
        case (op)
            ALU_ADD: begin r = a[31:0] + b[31:0]; f = a + b; return w ? sx(r) : f; end
            ALU_SUB: begin r = a[31:0] - b[31:0]; f = a - b; return w ? sx(r) : f; end
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: begin r = a[31:0] << b[4:0]; f = a << b[5:0]; return w ? sx(r) : f; end
            ALU_SRL: begin r = a[31:0] >> b[4:0]; f = a >> b[5:0]; return w ? sx(r) : f; end
            ALU_SRA: begin
                r = (a[31:0] >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
                f = (a >> b[5:0]) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> b[5:0]) : 64'd0);
                return w ? sx(r) : f;
            end
            ALU_SLT:  return {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {63'd0, a < b};
            ALU_LUI:  return a + {{32{b[19]}}, b[19:0], 12'b0};
            default:  return 64'd0;
        endcase
    endfunction

    task automatic cycle();
        exp_t e;
        logic rst_s;
        logic fl_s;
        @(negedge clk);
        rst_s     = i_rst;
        fl_s      = i_flush;
        last_ordy = o_ready;
        last_acc  = i_valid && o_ready && !i_rst;
        sb_n      = sb.size();
        if (!rst_s && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("dest", o_dest, e.data);
                chk("tag", 64'(o_tag), 64'(e.tag));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
                got_tags.push_back(o_tag);
            end
        end
        if (last_acc) begin
            e.data = cur_exp;
            e.tag  = i_tag;
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s || fl_s) sb.delete();
    endtask

    task automatic set_op(input decode_alu_op_t op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] t, input logic [63:0] exp);
        i_op    = op;
        i_w32   = w;
        i_src1  = a;
        i_src2  = b;
        i_tag   = t;
        cur_exp = exp;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run1(input decode_alu_op_t op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input logic [63:0] exp);
        int n = 0;
        set_op(op, w, a, b, t, exp);
        i_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 10);
        if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        logic seen_fall;
        decode_alu_op_t ops[8];
        logic [63:0] a;
        logic [63:0] b;

        ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL,
                ALU_SRA, ALU_SLTU, ALU_LUI, ALU_OR};

        // reset state
        i_rst = 1'b1;
        cycle();
        cycle();
        i_rst = 1'b0;
        chk("rst_ovalid", 64'(o_valid), 64'd0);
        chk("rst_odest", o_dest, 64'd0);
        chk("rst_otag", 64'(o_tag), 64'd0);
        chk("rst_oready", 64'(o_ready), 64'd1);

        // directed ops, each checked for value, tag and latency
        run1(ALU_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 6'd1, 64'hFFFF_FFFF_8000_0000);
        run1(ALU_ADD, 1'b0, 64'h7FFF_FFFF, 64'd1, 6'd2, 64'h0000_0000_8000_0000);
        run1(ALU_SRA, 1'b1, 64'h8000_0000, 64'd4, 6'd3, 64'hFFFF_FFFF_F800_0000);
        run1(ALU_SRA, 1'b0, 64'h8000_0000, 64'd4, 6'd4, 64'h0000_0000_0800_0000);
        run1(ALU_SLL, 1'b0, 64'd5, 64'h41, 6'd5, 64'hA);
        run1(ALU_LUI, 1'b0, 64'd0, 64'h80000, 6'd6, 64'hFFFF_FFFF_8000_0000);
        run1(ALU_SLT, 1'b0, '1, 64'd1, 6'd7, 64'd1);
        run1(ALU_SLTU, 1'b0, '1, 64'd1, 6'd8, 64'd0);
        run1(ALU_SUB, 1'b1, 64'd0, 64'd1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        run1(ALU_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 6'd10, 64'h0000_0000_0800_0000);
        run1(ALU_SRL, 1'b0, 64'h8000_0000_0000_0000, 64'h3F, 6'd11, 64'd1);
        run1(ALU_AND, 1'b1, 64'hFFFF_0000_FFFF_0000, '1, 6'd12, 64'hFFFF_0000_FFFF_0000);
        run1(decode_alu_op_t'(4'hF), 1'b0, '1, '1, 6'd13, 64'd0);

        // stream of 8 tagged ops with a consumer stall
        got_tags.delete();
        lat_chk   = 1'b0;
        sent      = 0;
        seen_fall = 1'b0;
        for (int c = 0; c < 60 && (sent < 8 || sb.size() > 0); c++) begin
            i_ready = !(c >= 4 && c <= 9);
            i_valid = (sent < 8);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            set_op(ops[sent % 8], sent[0], a, b, TAG_W'(sent),
                   model(ops[sent % 8], sent[0], a, b));
            cycle();
            if (last_acc) sent++;
            if (!last_ordy && !seen_fall) begin
                seen_fall = 1'b1;
                chk("full_depth", 64'(sb_n), 64'(STAGES));
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stream_seen_full", 64'(seen_fall), 64'd1);
        chk("stream_count", 64'(got_tags.size()), 64'd8);
        for (int i = 0; i < got_tags.size(); i++) begin
            chk("stream_tag", 64'(got_tags[i]), 64'(i));
        end
        lat_chk = 1'b1;

        // flush with two ops in flight and a pending op
        set_op(ALU_ADD, 1'b0, 64'd1, 64'd2, 6'd20, 64'd3);
        i_valid = 1'b1;
        cycle();
        set_op(ALU_ADD, 1'b0, 64'd3, 64'd4, 6'd21, 64'd7);
        cycle();
        set_op(ALU_ADD, 1'b0, 64'd5, 64'd6, 6'd22, 64'd11);
        i_flush = 1'b1;
        cycle();
        chk("flush_oready", 64'(last_ordy), 64'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_ovalid", 64'(o_valid), 64'd0);
        run1(ALU_XOR, 1'b0, 64'hF0, 64'hFF, 6'd23, 64'h0F);

        // reset in the middle of a stream
        set_op(ALU_OR, 1'b0, 64'h1, 64'h2, 6'd30, 64'h3);
        i_valid = 1'b1;
        cycle();
        set_op(ALU_OR, 1'b0, 64'h4, 64'h8, 6'd31, 64'hC);
        cycle();
        i_rst = 1'b1;
        cycle();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        chk("mrst_ovalid", 64'(o_valid), 64'd0);
        chk("mrst_odest", o_dest, 64'd0);
        chk("mrst_otag", 64'(o_tag), 64'd0);
        chk("mrst_oready", 64'(o_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("mrst_idle", 64'(o_valid), 64'd0);
        end
        run1(ALU_SUB, 1'b0, 64'd10, 64'd3, 6'd33, 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU for the execute stage. Takes one decoded ALU operation per cycle through a valid/ready handshake. Results come out in order after a configurable number of register stages, each tagged with the issuing tag. Over the single-cycle combinational ALU it adds RV64 word (`W32`) mode, RV64-correct `LUI` sign extension, back-pressure and pipeline flush.

## Interface
Parameters:
- `XLEN`, 64: datapath width; legal values 32 or 64. `i_w32` is ignored when `XLEN` = 32.
- `STAGES`, 2: pipeline depth (latency in cycles); legal range 1..4.
- `TAG_W`, 6: width of the issue tag carried alongside the data.

Ports:
- `i_clk`  in  1  clock; one clock domain for the whole block.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_log_fd`  in  32  trace file descriptor; 0 disables tracing.
- `i_flush`  in  1  kill every in-flight operation.
- `i_valid`  in  1  an operation is presented this cycle.
- `o_ready`  out  1  the block accepts the operation this cycle.
- `i_op`  in  `decode_alu_op_t`  operation code.
- `i_w32`  in  1  word mode (`ADDW`/`SUBW`/`SLLW`/`SRLW`/`SRAW`).
- `i_src1`, `i_src2`  in  `XLEN`  operands.
- `i_tag`  in  `TAG_W`  issue tag.
- `o_valid`  out  1  a result is presented.
- `i_ready`  in  1  the consumer takes the result.
- `o_dest`  out  `XLEN`  result.
- `o_tag`  out  `TAG_W`  tag of the result.

## Operation
- **Accept:** an operation is accepted when `i_valid & o_ready`.
- **Compute:** the result is computed combinationally from the inputs in the accept cycle and captured into stage 0. Stages 1..`STAGES`-1 only move data.
- **Ops, full width:**
  - `ADD`, `SUB`, `AND`, `OR`, `XOR`.
  - `SLL`/`SRL`/`SRA` use shift amount `src2[log2(XLEN)-1:0]`.
  - `SLT` is a signed compare and `SLTU` an unsigned compare; each gives 1 or 0.
  - `LUI` = `src1` + sext32({`src2[19:0]`, 12'b0}).
  - An undefined op gives 0.
- **W32 mode** (`XLEN` = 64 and `i_w32` = 1): applies to `ADD`/`SUB`/`SLL`/`SRL`/`SRA`.
  - The op works on `src1[31:0]` and `src2[31:0]`, with shift amount `src2[4:0]`.
  - `SRL` zero-fills from bit 31 and `SRA` fills with `src1[31]`.
  - The 32-bit result is sign-extended from bit 31.
  - For all other ops `i_w32` is ignored.
- **Stage advance:** each stage holds a valid bit, data and tag. Stage k advances when stage k+1 is empty or advancing. The last stage advances on `i_ready`.
- **`o_ready`:** `o_ready` = ~`i_flush` & (~valid[0] | advance[0]). Throughput is one operation per cycle with no bubbles under continuous `i_ready`.
- **Ordering:** results are strictly in order. Data and tag are never dropped or duplicated except on flush.
- **Flush:** `i_flush` clears every valid bit at the next edge. No operation is accepted in the flush cycle. A result presented during the flush cycle may be taken by the consumer; it is not re-presented.
- **Trace:** when `i_log_fd` ≠ 0, each accept prints op, `src1`, `src2`, `w32`, dest and tag.

## Timing
- **Reset:** all valid bits, data and tags are 0. `o_valid` = 0, `o_dest` = 0, `o_tag` = 0. `o_ready` is 1 from the first cycle after `i_rst` deasserts.
- **Reset mid-operation:** every in-flight result is discarded with no output. `i_rst` takes priority over `i_flush` and over accept.
- **Latency:** an operation accepted in cycle N has `o_valid` = 1 in cycle N+`STAGES`, given no stalls.
- **Stall:** while `o_valid` & ~`i_ready`, `o_dest` and `o_tag` hold stable. Upstream stages keep filling bubbles. When all `STAGES` are full, `o_ready` falls.
- **Simultaneous events:** accept and output in the same cycle on a full pipe is legal. With `STAGES` = 1 this gives 1 op/cycle while `i_ready` = 1.
- **Outputs:** all outputs are registered except `o_ready`, which is combinational from valid bits, `i_ready` and `i_flush`.

## Structure
- **Shared package:** `decode_alu_op_t` and `reg_data_t` stay in the shared instruction/config package. Add `ALU_SHAMT_W(XLEN)` there as a helper constant.
- **Sub-module `alu_pipe_core`:** purely combinational. Inputs `op`, `w32`, `src1`, `src2`; output `XLEN` result. It is the only arithmetic logic.
- **Pipeline:** the top level holds the `STAGES`-deep valid/data/tag register array built with a generate loop.

## Test plan
1. `XLEN` = 64, `STAGES` = 2: `ADD` 0x7FFF_FFFF + 1 with `w32` = 1 -> `o_dest` 0xFFFF_FFFF_8000_0000 two cycles after accept; with `w32` = 0 -> 0x0000_0000_8000_0000.
2. `SRA` `src1` = 0x0000_0000_8000_0000, `src2` = 4, `w32` = 1 -> 0xFFFF_FFFF_F800_0000; `w32` = 0 -> 0x0000_0000_0800_0000. `SLL` with `src2` = 0x41 (`w32` = 0) shifts by 1.
3. `LUI` `src1` = 0, `src2` = 0x80000 -> 0xFFFF_FFFF_8000_0000. `SLT` −1 vs 1 -> 1; `SLTU` −1 vs 1 -> 0.
4. `STAGES` = 3, stream 8 tagged ops with `i_ready` low for cycles 4–9: no loss or reorder; `o_ready` falls after 3 accepted ops; tags exit 0..7 in order.
5. Assert `i_flush` with 2 ops in flight plus `i_valid` high: nothing accepted that cycle, `o_valid` = 0 next cycle, and a subsequent op emerges after exactly `STAGES` cycles.
6. Assert `i_rst` mid-stream: all outputs read 0 the cycle after, and no stale tag appears afterwards.
